double_dabble_bcd: RTL and testbench

DOUBLE_DABBLE_BCD -- requirements
Module: double_dabble

---
 rtl/double_dabble_bcd.sv | 66 ++++++
 tb/tb_double_dabble_bcd.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/double_dabble_bcd.sv
// -----------------------------------------------------------------------------
// double_dabble_bcd
//
// Purpose:
//   Converts an 8-bit unsigned binary value into three packed BCD digits.
//   The conversion uses the shift-and-add-3 (double-dabble) algorithm.
//   All 8 iterations are unrolled into combinational logic, so a result is
//   ready within one clock cycle. The result is captured in a single output
//   register. Latency is one cycle and a new value is accepted every cycle.
//
// Ports:
//   clk    in   1   single clock, rising-edge active
//   rst_n  in   1   synchronous active-low reset; clears bcd to 12'h000
//   bin    in   8   unsigned binary value to convert (0..255)
//   bcd    out  12  registered BCD result: [11:8] hundreds, [7:4] tens,
//                   [3:0] ones
//
// Interface notes:
//   There is no handshake and no valid strobe. On every rising edge with
//   rst_n=1, bcd loads the conversion of the bin value present at that edge.
//   Reset takes priority over that load.
// -----------------------------------------------------------------------------
module double_dabble_bcd (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  bin,
    output logic [11:0] bcd
);

    // Combinational conversion result, fed into the output register.
    logic [11:0] bcd_next;

    // The working register is {hundreds, tens, ones, binary}.
    // In each iteration, any BCD column holding 5 or more gets +3 before
    // the shift, so that the shift carries correctly into the next decade.
    // After 8 shifts, every binary bit has moved into the BCD field.
    // For inputs up to 255 the hundreds column never exceeds 2, so the
    // 12-bit BCD field cannot overflow.
    always_comb begin
        logic [19:0] work;
        work = {12'd0, bin};
        for (int i = 0; i < 8; i++) begin
            if (work[11:8] >= 4'd5) begin
                work[11:8] = work[11:8] + 4'd3;
            end
            if (work[15:12] >= 4'd5) begin
                work[15:12] = work[15:12] + 4'd3;
            end
            if (work[19:16] >= 4'd5) begin
                work[19:16] = work[19:16] + 4'd3;
            end
            work = {work[18:0], 1'b0};
        end
        bcd_next = work[19:8];
    end

    // Output register. It is the only state element in the block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd <= 12'h000;
        end else begin
            bcd <= bcd_next;
        end
    end

endmodule

// File: tb/tb_double_dabble_bcd.sv
// -----------------------------------------------------------------------------
// tb_double_dabble_bcd
//
// Purpose:
//   Table-driven bench for double_dabble_bcd. It covers:
//   - the reset sequence;
//   - directed vectors, including the digit thresholds;
//   - a back-to-back sweep of all inputs, checked through an expected queue;
//   - a change of bin between edges;
//   - rst_n toggled between edges;
//   - a one-edge reset during streaming.
//   The bench ends with a single summary line.
// -----------------------------------------------------------------------------
module tb_double_dabble_bcd;

    logic        clk;
    logic        rst_n;
    logic [7:0]  bin;
    logic [11:0] bcd;

    int n_vec;
    int n_bad;

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[14];
    logic [11:0] exp_q[$];

    double_dabble_bcd dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bin   (bin),
        .bcd   (bcd)
    );

    // Clock: 10 time-unit period, first rising edge at t=5.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Compare one output value against its expected value.
    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %03h expected %03h", name, act, exp);
        end
    endtask

    // Wait for the next rising edge, then sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: split a value into decimal digits.
    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    initial begin
        logic [11:0] held;
        logic [11:0] e;
        n_vec = 0;
        n_bad = 0;

        // Directed vectors with hand-computed results.
        vecs[0]  = '{8'd0,   12'h000};
        vecs[1]  = '{8'd45,  12'h045};
        vecs[2]  = '{8'd167, 12'h167};
        vecs[3]  = '{8'd255, 12'h255};
        vecs[4]  = '{8'd65,  12'h065};
        vecs[5]  = '{8'd99,  12'h099};
        vecs[6]  = '{8'd100, 12'h100};
        vecs[7]  = '{8'd199, 12'h199};
        vecs[8]  = '{8'd200, 12'h200};
        vecs[9]  = '{8'd1,   12'h001};
        vecs[10] = '{8'd9,   12'h009};
        vecs[11] = '{8'd10,  12'h010};
        vecs[12] = '{8'd128, 12'h128};
        vecs[13] = '{8'd254, 12'h254};

        // Reset: hold rst_n low for two edges with bin=255, then release.
        rst_n = 1'b0;
        bin   = 8'd255;
        tick();
        check("reset_edge1", bcd, 12'h000);
        tick();
        check("reset_edge2", bcd, 12'h000);
        rst_n = 1'b1;
        tick();
        check("reset_release", bcd, 12'h255);

        // Directed table: one value per cycle, checked one edge later.
        for (int i = 0; i < 14; i++) begin
            bin = vecs[i].bin;
            tick();
            check($sformatf("vec_%0d", vecs[i].bin), bcd, vecs[i].exp);
        end

        // Exhaustive sweep 0..255, back to back.
        for (int v = 0; v < 256; v++) begin
            bin = 8'(v);
            exp_q.push_back(to_bcd(v));
            tick();
            e = exp_q.pop_front();
            check($sformatf("sweep_%0d", v), bcd, e);
            n_vec++;
            if ($isunknown(bcd) || bcd[11:8] > 4'd2 || bcd[7:4] > 4'd9 || bcd[3:0] > 4'd9) begin
                n_bad++;
                $display("FAIL sweep_range_%0d: got %03h expected valid digits", v, bcd);
            end
        end

        // Change bin between edges: bcd must hold until the next edge.
        bin = 8'd45;
        tick();
        check("midcycle_load", bcd, 12'h045);
        #2 bin = 8'd200;
        #2;
        check("midcycle_hold", bcd, 12'h045);
        tick();
        check("midcycle_next_edge", bcd, 12'h200);

        // Toggle rst_n between edges: it must have no asynchronous effect.
        held = bcd;
        #1 rst_n = 1'b0;
        #2;
        check("async_assert_no_effect", bcd, held);
        rst_n = 1'b1;
        bin = 8'd73;
        tick();
        check("async_then_load", bcd, 12'h073);

        // One-edge reset in the middle of a stream.
        bin = 8'd120;
        tick();
        check("stream_before_rst", bcd, 12'h120);
        bin = 8'd121;
        rst_n = 1'b0;
        tick();
        check("stream_rst_edge", bcd, 12'h000);
        #2 rst_n = 1'b1;
        #1;
        check("stream_release_no_async", bcd, 12'h000);
        bin = 8'd122;
        tick();
        check("stream_resume", bcd, 12'h122);
        bin = 8'd123;
        tick();
        check("stream_resume2", bcd, 12'h123);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
